uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, 2..16).
REQ-002 SHALL have port i_clk  input  1  single clock for all logic.
REQ-003 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_uart_rx  input  1  serial line, idle high, asynchronous to i_clk.
REQ-005 SHALL have port i_baud_div  input  24  i_clk cycles per bit (434 = 115200 baud at 50 MHz).
REQ-006 SHALL have port o_data  output  8  byte at FIFO head.
REQ-007 SHALL have port o_valid  output  1  FIFO non-empty; o_data valid.
REQ-008 SHALL have port i_ready  input  1  consumer accepts o_data.
REQ-009 SHALL have port o_frame_err  output  1  sticky stop-bit error.
REQ-010 SHALL have port o_overrun  output  1  sticky byte-dropped-on-full flag.
REQ-011 SHALL have port i_clear_err  input  1  clears sticky error flags.
REQ-012 SHALL have port o_busy  output  1  frame in progress (state not IDLE).
REQ-013 SHALL have port o_level  output  5  FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-014 SHALL pass i_uart_rx through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-015 SHALL implement states IDLE, START, DATA, STOP (plus PARITY when enabled), 8 data bits LSB first.
REQ-016 SHALL latch i_baud_div on leaving IDLE; changes mid-frame have no effect until the next frame; latched values below 2 are treated as 2.
REQ-017 IDLE -> START when synchronized line is 0; bit counter loaded with div/2 (integer) for mid-bit sampling.
REQ-018 START: at mid-bit, line 1 -> IDLE (glitch, nothing pushed, no flag); line 0 -> DATA.
REQ-019 DATA: sample every div cycles at bit centre; after 8th bit -> STOP (or PARITY).
REQ-020 STOP: sample at bit centre; 1 -> push byte, -> IDLE; 0 -> set o_frame_err, discard byte, remain in STOP until line returns 1, then -> IDLE (break handling).
REQ-021 SHALL push into FIFO on the stop-sample cycle; o_valid rises the following i_clk edge when FIFO was empty; o_data is FIFO head, first-word fall-through.
REQ-022 SHALL pop when o_valid && i_ready; i_ready without o_valid has no effect.
REQ-023 Push when full and no pop same cycle: byte dropped, o_overrun set, FIFO contents unchanged.
REQ-024 Push and pop same cycle when full: both occur, level unchanged, no overrun.
REQ-025 Pointers wrap modulo FIFO_DEPTH; o_level = FIFO_DEPTH when full.
REQ-026 i_clear_err clears o_frame_err and o_overrun; a set event in the same cycle wins.

Reset
REQ-027 While i_reset_n = 0: state IDLE, synchronizer flops 1, FIFO empty, o_valid 0, o_data 0, o_level 0, o_busy 0, o_frame_err 0, o_overrun 0, o_parity_err 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no push; after release a line still low SHALL NOT start a frame until a 1 is seen.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: PARITY state after bit 8 checks even parity; port o_parity_err (output 1, sticky, cleared by i_clear_err) set on mismatch; byte is still pushed.
REQ-030 Macro UART_RX_PARITY_EN undefined: no PARITY state, no o_parity_err port, frame is 8N1.

Verification
REQ-031 div=434, send 0xA5 8N1, i_ready=1 -> o_valid pulse with o_data=0xA5 within 10*434+4 cycles of start edge; no flags.
REQ-032 100-cycle low glitch on idle line, div=434 -> no push, o_busy returns 0, no flags.
REQ-033 Send 0x3C with stop bit 0, line held low 2000 cycles then high -> o_frame_err=1, o_level=0; next byte 0x55 received correctly.
REQ-034 i_ready=0, send 0x01..0x05 -> o_level=4, o_overrun=1, pops yield 0x01..0x04 in order; i_clear_err -> o_overrun=0.
REQ-035 Assert i_reset_n=0 during DATA bit 4 of 0xFF -> no push, all outputs at reset values; following 0x81 received correctly.
REQ-036 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> o_data=0x07 pushed, o_parity_err=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a sticky o_parity_err output.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_uart_rx,
  input  logic [23:0] i_baud_div,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_frame_err,
  output logic        o_overrun,
  input  logic        i_clear_err,
`ifdef UART_RX_PARITY_EN
  output logic        o_parity_err,
`endif
  output logic        o_busy,
  output logic [4:0]  o_level
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state_q, state_d;
  logic sync1_q, sync2_q, rx_s;
  logic [1:0] settle_q;
  logic armed_q;
  logic [23:0] div_q, div_d, cnt_q, cnt_d, div_eff;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic brk_q, brk_d;
  logic frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic tick, push, fe_set, pe_set, pop, full, wr_en;
  logic [AW-1:0] wr_q, rd_q;
  logic [4:0] level_q, level_d;
  logic [7:0] mem [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
  logic par_err_q;
  assign o_parity_err = par_err_q;
`endif
  assign rx_s = sync2_q;
  assign div_eff = (i_baud_div < 24'd2) ? 24'd2 : i_baud_div;
  assign tick = cnt_q == '0;
  assign pop = o_valid && i_ready;
  assign full = level_q == 5'(FIFO_DEPTH);
  assign wr_en = push && (!full || pop);
  assign level_d = level_q + 5'(wr_en) - 5'(pop);
  assign frame_err_d = fe_set | (frame_err_q & ~i_clear_err);
  assign overrun_d = (push && full && !pop) | (overrun_q & ~i_clear_err);
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    cnt_d = tick ? div_q - 24'd1 : cnt_q - 24'd1;
    bit_d = bit_q;
    shift_d = shift_q;
    brk_d = brk_q;
    push = 1'b0;
    fe_set = 1'b0;
    pe_set = 1'b0;
    case (state_q)
      IDLE: if (armed_q && !rx_s) begin
        state_d = START;
        div_d = div_eff;
        cnt_d = div_eff >> 1;
      end
      START: if (tick) begin
        state_d = rx_s ? IDLE : DATA;
        bit_d = '0;
      end
      DATA: if (tick) begin
        shift_d = {rx_s, shift_q[7:1]};
        bit_d = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? AFTER_DATA : DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        pe_set = ^{shift_q, rx_s};
        state_d = STOP;
      end
`endif
      STOP: if (brk_q) begin
        // line held low past the stop bit: wait for idle before re-arming
        state_d = rx_s ? IDLE : STOP;
        brk_d = !rx_s;
      end else if (tick) begin
        push = rx_s;
        fe_set = !rx_s;
        brk_d = !rx_s;
        state_d = rx_s ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      settle_q <= '0;
      armed_q <= 1'b0;
      div_q <= 24'd2;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      brk_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= i_uart_rx;
      sync2_q <= sync1_q;
      // arm only once a real (post-reset) high has reached the synchronizer output
      settle_q <= {settle_q[0], 1'b1};
      armed_q <= armed_q | (settle_q[1] & rx_s);
      div_q <= div_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      brk_q <= brk_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
      wr_q <= wr_en ? wr_q + AW'(1) : wr_q;
      rd_q <= pop ? rd_q + AW'(1) : rd_q;
      level_q <= level_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= pe_set | (par_err_q & ~i_clear_err);
`endif
    end
  end
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_q] <= shift_q;
  end
  assign o_valid = level_q != '0;
  assign o_data = o_valid ? mem[rd_q] : '0;
  assign o_level = level_q;
  assign o_busy = state_q != IDLE;
  assign o_frame_err = frame_err_q;
  assign o_overrun = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed serial frames against uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;
  logic i_clk = 1'b0, i_reset_n = 1'b0, i_uart_rx = 1'b1, i_ready = 1'b0, i_clear_err = 1'b0;
  logic [23:0] i_baud_div = 24'd434;
  logic [7:0] o_data;
  logic o_valid, o_frame_err, o_overrun, o_busy;
  logic [4:0] o_level;
`ifdef UART_RX_PARITY_EN
  logic o_parity_err;
`endif
  int n_vec = 0, n_bad = 0, cyc = 0, t0 = 0, lat = 0;
  logic [7:0] got_q[$];
  int got_cyc[$];

  uart_rx_fifo dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_uart_rx(i_uart_rx), .i_baud_div(i_baud_div),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_frame_err(o_frame_err),
    .o_overrun(o_overrun), .i_clear_err(i_clear_err),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(o_parity_err),
`endif
    .o_busy(o_busy), .o_level(o_level)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  always @(negedge i_clk) if (o_valid && i_ready) begin
    got_q.push_back(o_data);
    got_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send(input logic [7:0] b, input bit stop, input bit bad_par, input int bt);
`ifdef UART_RX_PARITY_EN
    logic [10:0] f;
    f = {stop, ^b ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
`else
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
`endif
      i_uart_rx = f[i];
      idle(bt);
    end
    i_uart_rx = 1'b1;
  endtask

  task automatic clr_got();
    got_q.delete();
    got_cyc.delete();
  endtask

  function automatic logic [31:0] head();
    return (got_q.size() > 0) ? 32'(got_q[0]) : 32'hdead;
  endfunction

  initial begin
    idle(3);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_level", o_level, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ferr", o_frame_err, 0);
    chk("rst_ovr", o_overrun, 0);
    i_reset_n = 1'b1;
    idle(5);
    i_ready = 1'b1;
    clr_got();
    t0 = cyc;
    send(8'hA5, 1, 0, 434);
    idle(20);
    chk("a5_count", got_q.size(), 1);
    chk("a5_data", head(), 8'hA5);
    lat = (got_cyc.size() > 0) ? got_cyc[0] - t0 : 99999;
    chk("a5_latency_ok", lat <= 10 * 434 + 4, 1);
    chk("a5_ferr", o_frame_err, 0);
    chk("a5_ovr", o_overrun, 0);
    chk("a5_level", o_level, 0);
    clr_got();
    i_uart_rx = 1'b0;
    idle(50);
    chk("glitch_busy_mid", o_busy, 1);
    idle(50);
    i_uart_rx = 1'b1;
    idle(434);
    chk("glitch_busy_end", o_busy, 0);
    chk("glitch_count", got_q.size(), 0);
    chk("glitch_ferr", o_frame_err, 0);
    chk("glitch_ovr", o_overrun, 0);
    send(8'h3C, 0, 0, 434);
    i_uart_rx = 1'b0;
    idle(2000);
    chk("break_busy", o_busy, 1);
    chk("break_ferr", o_frame_err, 1);
    i_uart_rx = 1'b1;
    idle(20);
    chk("break_idle", o_busy, 0);
    chk("break_level", o_level, 0);
    chk("break_count", got_q.size(), 0);
    send(8'h55, 1, 0, 434);
    idle(20);
    chk("after_break_data", head(), 8'h55);
    chk("ferr_sticky", o_frame_err, 1);
    i_clear_err = 1'b1;
    idle(1);
    i_clear_err = 1'b0;
    chk("ferr_clear", o_frame_err, 0);
    clr_got();
    i_baud_div = 24'd20;
    i_ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      send(8'(b), 1, 0, 20);
      idle(20);
    end
    chk("ovr_level", o_level, 4);
    chk("ovr_flag", o_overrun, 1);
    chk("ovr_valid", o_valid, 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("pop%0d_data", i), o_data, i);
      i_ready = 1'b1;
      idle(1);
      i_ready = 1'b0;
    end
    chk("drain_level", o_level, 0);
    chk("drain_valid", o_valid, 0);
    i_clear_err = 1'b1;
    idle(1);
    i_clear_err = 1'b0;
    chk("ovr_clear", o_overrun, 0);
    clr_got();
    i_ready = 1'b1;
    fork
      send(8'h5A, 1, 0, 20);
      begin
        idle(30);
        i_baud_div = 24'd7;
      end
    join
    idle(20);
    chk("divchg_data", head(), 8'h5A);
    i_baud_div = 24'd20;
    clr_got();
    i_uart_rx = 1'b0;
    idle(20);
    i_uart_rx = 1'b1;
    idle(90);
    chk("midrst_busy", o_busy, 1);
    i_reset_n = 1'b0;
    idle(2);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_data", o_data, 0);
    chk("midrst_level", o_level, 0);
    chk("midrst_busy_rst", o_busy, 0);
    chk("midrst_ferr", o_frame_err, 0);
    chk("midrst_ovr", o_overrun, 0);
    i_uart_rx = 1'b0;
    idle(5);
    i_reset_n = 1'b1;
    idle(100);
    chk("low_after_rst_busy", o_busy, 0);
    i_uart_rx = 1'b1;
    idle(40);
    chk("midrst_count", got_q.size(), 0);
    send(8'h81, 1, 0, 20);
    idle(20);
    chk("after_rst_data", head(), 8'h81);
    chk("after_rst_ferr", o_frame_err, 0);
`ifdef UART_RX_PARITY_EN
    chk("par_ok_flag", o_parity_err, 0);
    clr_got();
    send(8'h07, 1, 1, 20);
    idle(20);
    chk("par_data", head(), 8'h07);
    chk("par_err", o_parity_err, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
